// File: rtl/mem_arbiter.sv
// Two-port (CPU / I/O loader) memory arbiter with round-robin tie-break.
// Each access holds the memory strobes for ACCESS_CYCLES cycles, then acks.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access in flight; a request is granted on the next edge
// ACCESS | strobes asserted; counter runs down to terminal count 0
// DONE   | one-cycle ack to the winner; strobes low
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        io_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        busy,
  output logic        grant_io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        lat_we;
  logic        win_io;
  logic        grant_now;
  logic        last_cycle;

  // On a tie the port that did not win last time gets the grant.
  assign win_io     = io_req && (!cpu_req || !grant_io);
  assign grant_now  = (state == IDLE) && (cpu_req || io_req);
  assign last_cycle = (state == ACCESS) && (cnt == 3'd0);

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req || io_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 3'd0)       state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner's request is latched at grant so later port changes cannot disturb it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt       <= 3'd0;
      lat_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 16'd0;
      grant_io  <= 1'b1;
      cpu_rdata <= 16'd0;
      io_rdata  <= 16'd0;
    end else begin
      if (grant_now) begin
        grant_io  <= win_io;
        lat_we    <= win_io ? io_we    : cpu_we;
        mem_addr  <= win_io ? io_addr  : cpu_addr;
        mem_wdata <= win_io ? io_wdata : cpu_wdata;
        cnt       <= CNT_LOAD;
      end else if (state == ACCESS && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (last_cycle && !lat_we) begin
        if (grant_io) io_rdata  <= mem_rdata;
        else          cpu_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_oe  = 1'b0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    io_ack  = 1'b0;
    busy    = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_oe = !lat_we;
        mem_we = lat_we;
      end
      DONE: begin
        cpu_ack = !grant_io;
        io_ack  = grant_io;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 3, sets the number of cycles memory strobes stay asserted per access (legal range 1..7).
REQ-002 Clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Reset  in  1  one clock; reset is synchronous and active-low.
REQ-004 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-005 cpu_we  in  1  CPU write (1) / read (0).
REQ-006 cpu_addr  in  16  CPU address.
REQ-007 cpu_wdata  in  16  CPU write data.
REQ-008 cpu_rdata  out  16  CPU read data, registered.
REQ-009 cpu_ack  out  1  one-cycle CPU completion pulse.
REQ-010 io_req, io_we, io_addr[15:0], io_wdata[15:0]  in  I/O-loader port, same meaning as the CPU port.
REQ-011 io_rdata  out  16 and io_ack  out  1: same meaning as the CPU port.
REQ-012 mem_addr  out  16  memory address.
REQ-013 mem_wdata  out  16  memory write data.
REQ-014 mem_rdata  in  16  memory read data.
REQ-015 mem_oe, mem_we  out  1 each  active-high memory strobes.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 grant_io  out  1  0 = CPU owns the current or last access, 1 = I/O owns it.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-019 IDLE, no request -> stay in IDLE; all strobes low.
REQ-020 IDLE, one request -> grant that port; go to ACCESS next edge.
REQ-021 IDLE, both requests -> grant the port not granted last (round-robin).
REQ-022 Grant edge: latch addr, we and wdata of the winner into internal registers; mem_addr and mem_wdata SHALL drive those registers only.
REQ-023 ACCESS SHALL last exactly ACCESS_CYCLES cycles, counted by a 3-bit counter loaded at grant.
REQ-024 ACCESS, latched write -> mem_we=1, mem_oe=0 for every ACCESS cycle.
REQ-025 ACCESS, latched read -> mem_oe=1, mem_we=0 for every ACCESS cycle.
REQ-026 Read: mem_rdata sampled on the edge ending the last ACCESS cycle into the winner's rdata register; the other port's rdata is unchanged.
REQ-027 The rdata registers SHALL hold their value until that port's next completed read; writes do not modify them.
REQ-028 DONE SHALL last one cycle: winner's ack=1, strobes low; then IDLE.
REQ-029 Latency: request seen in IDLE at cycle N -> ack at cycle N+1+ACCESS_CYCLES; next grant earliest at N+2+ACCESS_CYCLES.
REQ-030 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-031 Request inputs SHALL be ignored outside IDLE; a request dropped mid-access does not abort it, and ack is still issued.
REQ-032 mem_oe and mem_we SHALL never be high in the same cycle.
REQ-033 grant_io SHALL update only on a grant edge.

Reset
REQ-034 Reset=0 at a rising edge -> state IDLE, counter 0, cpu_ack=io_ack=0, mem_oe=mem_we=0, busy=0.
REQ-035 Same reset -> cpu_rdata=io_rdata=0, mem_addr=mem_wdata=0, grant_io=1, so the CPU wins the first tie.
REQ-036 Reset asserted in ACCESS or DONE -> abort with no ack, strobes low the following cycle, no rdata update.

Verification
REQ-037 Single CPU read, ACCESS_CYCLES=3, cpu_addr=0x0010, mem_rdata=0xBEEF -> mem_oe high exactly cycles 1-3 after grant; cpu_ack in cycle 4; cpu_rdata=0xBEEF; io_ack stays 0.
REQ-038 I/O write io_addr=0x0200, io_wdata=0x1234 -> mem_we high 3 cycles with mem_addr=0x0200, mem_wdata=0x1234; io_ack one pulse; mem_oe stays 0.
REQ-039 Both requests held high from reset -> grants alternate CPU, I/O, CPU, I/O; acks alternate; mem_oe and mem_we never both high.
REQ-040 Reset in the 2nd ACCESS cycle of a CPU read -> no cpu_ack; strobes low next cycle; cpu_rdata=0; next tie granted to CPU.
REQ-041 CPU drops cpu_req in the 1st ACCESS cycle -> access completes with cpu_ack; a cpu_addr change after grant does not alter mem_addr.
REQ-042 ACCESS_CYCLES=1, back-to-back CPU reads -> ack every 3rd cycle; busy low one cycle between accesses.
